// File: rtl/channel_select_fifo.sv
// rtl/channel_select_fifo.sv - extract one channel from a channelizer stream into a small FWFT FIFO
// Optional: define CHANNEL_SELECT_FIFO_META_EN to carry in_m through the FIFO onto out_m.
module channel_select_fifo #(
    parameter int N     = 8,
    parameter int LOGN  = 3,
    parameter int WDTH  = 32,
    parameter int MWDTH = 1,
    parameter int LOGD  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WDTH-1:0]  in_data,
    input  logic             in_nd,
    input  logic [MWDTH-1:0] in_m,
    input  logic             in_first,
    input  logic [LOGN-1:0]  in_sel,
    output logic [WDTH-1:0]  out_data,
    output logic [MWDTH-1:0] out_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGD:0]    fill,
    output logic             error
);

    localparam int D = 1 << LOGD;
`ifdef CHANNEL_SELECT_FIFO_META_EN
    localparam int EW = WDTH + MWDTH;
`else
    localparam int EW = WDTH;
`endif

    logic [EW-1:0]   mem [D];
    logic [EW-1:0]   in_entry;
    logic [EW-1:0]   head_nxt;
    logic [LOGN-1:0] cnt;
    logic [LOGN-1:0] active_sel;
    logic            synced;
    logic            unaligned;
    logic            overflow;
    logic [LOGD-1:0] wr_ptr;
    logic [LOGD-1:0] rd_ptr;
    logic [LOGD-1:0] rd_ptr_nxt;
    logic [LOGD:0]   fill_nxt;
    logic            sel_hit;
    logic            push;
    logic            pop;
    logic            push_ok;

`ifdef CHANNEL_SELECT_FIFO_META_EN
    assign in_entry = {in_data, in_m};
`else
    logic unused_m;
    assign unused_m = ^in_m;
    assign in_entry = in_data;
    assign out_m    = '0;
`endif

    assign error = overflow | unaligned;

    always_comb begin
        // A frame-start sample is channel 0 and is judged against the live in_sel.
        sel_hit    = in_first ? (in_sel == '0) : (synced && (cnt == active_sel));
        push       = in_nd && sel_hit;
        pop        = out_valid && out_ready;
        push_ok    = push && ((fill != (LOGD+1)'(D)) || pop);
        rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
        fill_nxt   = fill;
        if (push_ok && !pop) begin
            fill_nxt = fill + 1'b1;
        end else if (!push_ok && pop) begin
            fill_nxt = fill - 1'b1;
        end
        // Head lands on the slot being written only when the FIFO would otherwise be empty.
        head_nxt = (push_ok && (rd_ptr_nxt == wr_ptr)) ? in_entry : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            active_sel <= '0;
            synced     <= 1'b0;
            unaligned  <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
`ifdef CHANNEL_SELECT_FIFO_META_EN
            out_m      <= '0;
`endif
        end else begin
            if (in_nd) begin
                if (in_first) begin
                    cnt        <= LOGN'(1);
                    active_sel <= in_sel;
                    synced     <= 1'b1;
                    if (synced && (cnt != '0)) begin
                        unaligned <= 1'b1;
                    end
                end else begin
                    cnt <= (cnt == LOGN'(N-1)) ? '0 : cnt + 1'b1;
                    if (synced && (cnt == '0)) begin
                        unaligned <= 1'b1;
                    end
                end
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            rd_ptr    <= rd_ptr_nxt;
            fill      <= fill_nxt;
            out_valid <= (fill_nxt != '0);
            if (fill_nxt != '0) begin
`ifdef CHANNEL_SELECT_FIFO_META_EN
                out_data <= head_nxt[EW-1:MWDTH];
                out_m    <= head_nxt[MWDTH-1:0];
`else
                out_data <= head_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_channel_select_fifo.sv
// tb/tb_channel_select_fifo.sv - directed self-checking bench for channel_select_fifo
module tb_channel_select_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_nd = 1'b0;
    logic [0:0]  in_m = '0;
    logic        in_first = 1'b0;
    logic [2:0]  in_sel = '0;
    logic [31:0] out_data;
    logic [0:0]  out_m;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  fill;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] cap [$];

    channel_select_fifo dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_nd    (in_nd),
        .in_m     (in_m),
        .in_first (in_first),
        .in_sel   (in_sel),
        .out_data (out_data),
        .out_m    (out_m),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fill     (fill),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic send(input logic first, input logic [31:0] d, input logic [2:0] sel);
        in_nd    = 1'b1;
        in_first = first;
        in_data  = d;
        in_sel   = sel;
        in_m     = 1'b1;
        @(posedge clk);
        #1;
        if (out_valid && out_ready) cap.push_back(out_data);
    endtask

    task automatic idle();
        in_nd    = 1'b0;
        in_first = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_nd = 1'b0;
        in_first = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cap.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
        if (out_m !== 1'b0) begin n_fail++; $display("FAIL reset_m got %b want 0", out_m); end
        if (fill !== 3'd0) begin n_fail++; $display("FAIL reset_fill got %0d want 0", fill); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < 8; c++) begin
                send(c == 0, 32'(16*f + c), 3'd3);
                n_checks += 2;
                if (out_valid !== (c == 3)) begin
                    n_fail++; $display("FAIL basic_valid f%0d c%0d got %b want %b", f, c, out_valid, c == 3);
                end
                if (fill > 3'd1) begin
                    n_fail++; $display("FAIL basic_fill f%0d c%0d got %0d want <=1", f, c, fill);
                end
                if (c == 3) begin
                    n_checks++;
                    if (out_data !== 32'(16*f + 3)) begin
                        n_fail++; $display("FAIL basic_data f%0d got %h want %h", f, out_data, 16*f + 3);
                    end
                end
            end
        end
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error got %b want 0", error); end
    endtask

    task automatic test_presync();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(1'b0, 32'hA0 + i, 3'd0);
        n_checks += 2;
        if (cap.size() != 0) begin n_fail++; $display("FAIL presync_out got %0d outputs want 0", cap.size()); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL presync_error got %b want 0", error); end
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 8; c++) send(c == 0, 32'(16*f + c), 3'd0);
        idle();
        n_checks += 3;
        if (cap.size() != 2) begin
            n_fail++; $display("FAIL presync_count got %0d want 2", cap.size());
        end else begin
            if (cap[0] !== 32'h00) begin n_fail++; $display("FAIL presync_first got %h want 00", cap[0]); end
            if (cap[1] !== 32'h10) begin n_fail++; $display("FAIL presync_second got %h want 10", cap[1]); end
        end
    endtask

    task automatic test_sel_change();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) send(c == 0, 32'(c), (c < 4) ? 3'd3 : 3'd6);
        for (int c = 0; c < 8; c++) send(c == 0, 32'(16 + c), 3'd6);
        idle();
        n_checks += 3;
        if (cap.size() != 2) begin
            n_fail++; $display("FAIL selchg_count got %0d want 2", cap.size());
        end else begin
            if (cap[0] !== 32'h03) begin n_fail++; $display("FAIL selchg_f0 got %h want 03", cap[0]); end
            if (cap[1] !== 32'h16) begin n_fail++; $display("FAIL selchg_f1 got %h want 16", cap[1]); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int f = 0; f < 4; f++)
            for (int c = 0; c < 8; c++) send(c == 0, 32'(16*f + c), 3'd2);
        n_checks += 2;
        if (fill !== 3'd4) begin n_fail++; $display("FAIL ovf_fill4 got %0d want 4", fill); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL ovf_pre_error got %b want 0", error); end
        for (int f = 4; f < 6; f++)
            for (int c = 0; c < 8; c++) send(c == 0, 32'(16*f + c), 3'd2);
        n_checks += 2;
        if (fill !== 3'd4) begin n_fail++; $display("FAIL ovf_fill_hold got %0d want 4", fill); end
        if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_error got %b want 1", error); end
        in_nd = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks += 2;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_valid %0d got %b want 1", i, out_valid); end
            if (out_data !== 32'(16*i + 2)) begin
                n_fail++; $display("FAIL ovf_drain_data %0d got %h want %h", i, out_data, 16*i + 2);
            end
            @(posedge clk);
            #1;
        end
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty_valid got %b want 0", out_valid); end
        if (fill !== 3'd0) begin n_fail++; $display("FAIL ovf_empty_fill got %0d want 0", fill); end
        if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", error); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        for (int f = 0; f < 4; f++)
            for (int c = 0; c < 8; c++) send(c == 0, 32'(16*f + c), 3'd2);
        for (int c = 0; c < 8; c++) begin
            out_ready = (c == 2);
            send(c == 0, 32'(64 + c), 3'd2);
            out_ready = 1'b0;
            if (c == 2) begin
                n_checks += 3;
                if (fill !== 3'd4) begin n_fail++; $display("FAIL b2b_fill got %0d want 4", fill); end
                if (error !== 1'b0) begin n_fail++; $display("FAIL b2b_error got %b want 0", error); end
                if (out_data !== 32'h12) begin n_fail++; $display("FAIL b2b_head got %h want 12", out_data); end
            end
        end
        in_nd = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (!out_valid || out_data !== 32'(16*(i+1) + 2)) begin
                n_fail++; $display("FAIL b2b_order %0d got %b/%h want 1/%h", i, out_valid, out_data, 16*(i+1) + 2);
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (fill !== 3'd0) begin n_fail++; $display("FAIL b2b_empty got %0d want 0", fill); end
        out_ready = 1'b0;
    endtask

    task automatic test_unaligned();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) send(c == 0, 32'(c), 3'd1);
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL unal_pre got %b want 0", error); end
        send(1'b1, 32'h10, 3'd1);
        n_checks++;
        if (error !== 1'b1) begin n_fail++; $display("FAIL unal_error got %b want 1", error); end
        for (int c = 1; c < 8; c++) send(1'b0, 32'(16 + c), 3'd1);
        for (int c = 0; c < 8; c++) send(c == 0, 32'(32 + c), 3'd1);
        idle();
        n_checks += 4;
        if (cap.size() != 3) begin
            n_fail++; $display("FAIL unal_count got %0d want 3", cap.size());
        end else begin
            if (cap[0] !== 32'h01) begin n_fail++; $display("FAIL unal_c0 got %h want 01", cap[0]); end
            if (cap[1] !== 32'h11) begin n_fail++; $display("FAIL unal_c1 got %h want 11", cap[1]); end
            if (cap[2] !== 32'h21) begin n_fail++; $display("FAIL unal_c2 got %h want 21", cap[2]); end
        end
        out_ready = 1'b0;
        send(1'b1, 32'h30, 3'd1);
        send(1'b0, 32'h31, 3'd1);
        n_checks++;
        if (fill !== 3'd1) begin n_fail++; $display("FAIL unal_prefill got %0d want 1", fill); end
        do_reset();
        n_checks += 3;
        if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error got %b want 0", error); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
        if (fill !== 3'd0) begin n_fail++; $display("FAIL rst_fill got %0d want 0", fill); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) send(1'b0, 32'h50 + c, 3'd1);
        idle();
        n_checks += 2;
        if (cap.size() != 0) begin n_fail++; $display("FAIL rst_resync got %0d outputs want 0", cap.size()); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL rst_resync_err got %b want 0", error); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_presync();
        test_sel_change();
        test_overflow();
        test_back_to_back();
        test_unaligned();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
